ofs_plat_host_chan_rx_tlp_sequencer: RTL and testbench
======================================================

# ofs_plat_host_chan_rx_tlp_sequencer

Consumes the split RX header stream (one header per beat, at most one per cycle) and the bus-aligned RX payload stream produced by the host-channel RX TLP aligner. Re-pairs them in protocol order into a single per-packet stream: every header is followed by exactly its own payload. Checks payload length against the header length field. Sits between the RX aligner and the PIM host-channel RX request/completion routing logic.

## Interface
- `TDATA_WIDTH`, default 512 — payload bus width in bits; a multiple of 256.
- `HDR_WIDTH`, default 256 — header width; fixed by `pcie_ss_hdr_pkg`.
- `ERR_CNT_WIDTH`, default 16 — width of the saturating length-error counter.
- `clk`  in  1 — sole clock.
- `reset`  in  1 — **synchronous, active-high** reset.
- `hdr_tvalid` / `hdr_tready`  in / out  1 — header stream handshake.
- `hdr_tdata`  in  HDR_WIDTH — PU or DM header.
- `hdr_tuser`  in  1 — 0 = PU mode, 1 = DM mode.
- `data_tvalid` / `data_tready`  in / out  1 — payload stream handshake.
- `data_tdata`  in  TDATA_WIDTH — aligned payload.
- `data_tkeep`  in  TDATA_WIDTH/8 — byte enables.
- `data_tlast`  in  1 — last payload beat of the packet.
- `out_tvalid` / `out_tready`  out / in  1 — merged stream handshake.
- `out_hdr`  out  HDR_WIDTH — header; meaningful only when `out_sop` = 1.
- `out_dm_mode`  out  1 — header mode; meaningful only when `out_sop` = 1.
- `out_data`  out  TDATA_WIDTH — payload data.
- `out_keep`  out  TDATA_WIDTH/8 — payload byte enables.
- `out_sop`, `out_eop`  out  1 — packet boundary markers.
- `out_err_len`  out  1 — set on the `out_eop` beat of a packet with a length mismatch.
- `err_count`  out  ERR_CNT_WIDTH — saturating count of mismatched packets.

## Operation
- **Header decode**
  - `has_data` = `fmt_type[6]` (byte 0 of the header).
  - Expected payload bytes in PU mode = `length[9:0]`·4; a `length` of 0 means 1024 DW.
  - Expected payload bytes in DM mode = concatenation of the `length_h`, `length_m`, `length_l` header fields.
  - `exp_beats` = ceil(bytes / (TDATA_WIDTH/8)). Computed in 14 bits; a value of 0 is treated as 1.
- **FSM, state IDLE**
  - Header-only packet: when `hdr_tvalid`, `has_data` = 0 and there is output space, pop the header alone. Emit one beat: `sop` = 1, `eop` = 1, `keep` = 0, `data` = 0. Stay in IDLE.
  - Header with data: pop only when `hdr_tvalid`, `data_tvalid` and output space are all true. Pop header and first data beat together and emit a merged beat with `sop` = 1.
    - `beat_cnt` ← 1.
    - If `data_tlast` = 1, set `eop` = 1 and stay in IDLE.
    - Otherwise go to DATA.
  - Data beats never pop while in IDLE without a header.
- **FSM, state DATA**
  - Pop `data` only; the header is held off. Each pop emits a beat with `sop` = 0 and increments `beat_cnt`.
  - On `data_tlast`, emit `eop` = 1 and go to IDLE.
  - Extra beats beyond `exp_beats` are forwarded unchanged until `tlast`, never dropped.
- **Length check**
  - Mismatch = (`tlast` beat number ≠ `exp_beats`).
  - On mismatch: `out_err_len` = 1 on the `eop` beat, and `err_count` increments, saturating at all-ones.
  - Header-only packets never flag.
- **Output stage**: a 2-entry skid buffer. "Output space" = skid buffer not full.
  - `hdr_tready` = space ∧ IDLE ∧ (¬`has_data` ∨ `data_tvalid`).
  - `data_tready` = space ∧ (DATA ∨ (IDLE ∧ `hdr_tvalid` ∧ `has_data`)).
  - Neither ready depends on its own valid.
- **Reset**: state ← IDLE, `beat_cnt` ← 0, skid buffer emptied, `out_tvalid` ← 0, `out_err_len` ← 0, `err_count` ← 0.
  - Reset mid-packet abandons the packet; no `eop` is emitted.
  - After reset, `hdr_tready` and `data_tready` are 0 during the reset cycle, then follow the rules above.

## Timing
- Latency: input accept in cycle N gives `out_tvalid` in cycle N+1.
- Sustained throughput is 1 beat/cycle when `out_tready` is held high, including back-to-back packets and header-only packets.
- `out_*` holds stable while `out_tvalid` ∧ ¬`out_tready`.
- Capacity under stall: with `out_tready` low, at most 2 beats are accepted; both readies then drop in the next cycle.
- Simultaneous `data_tlast` and a waiting next header: the next header is not popped in the same cycle. It pops the following cycle, giving 1 beat/cycle overall.
- `err_count` updates in the cycle the erroneous `eop` beat enters the skid buffer.

## Structure
- The `has_data` decode, expected-byte decode and beat-count function belong in the host-channel FIM gasket package, shared with the TX path.
- Sub-module `ofs_plat_host_chan_rx_tlp_seq_skid`: a generic 2-entry skid buffer parameterised by payload width.
- FSM, counters and length check live in the top module.

## Test plan
- **PU memory write**, `length` = 32 DW (128 B), 2 data beats, `tlast` on beat 2 → 2 out beats: `sop` on beat 1, `eop` on beat 2, `out_err_len` = 0.
- **Header-only read request**, immediately followed by a 1-beat completion (`length` = 4) → out beat 1 has `sop` = `eop` = 1 and `keep` = 0; out beat 2 has `sop` = `eop` = 1 and `keep` = 0xFFFF; consecutive cycles.
- **Header 5 cycles ahead of its data** → no output until data arrives; `hdr_tready` = 0 meanwhile; the merged beat appears 1 cycle after data arrives.
- **Length mismatch**: PU `length` = 16 DW with 2 data beats → `out_err_len` = 1 on the second beat and `err_count` = 1. Then `length` = 0 (1024 DW, 64 beats) with 64 beats → no error.
- **Backpressure**: `out_tready` toggled randomly 50% across 100 mixed packets → output sequence equals input sequence, no beat lost or duplicated, stable data under stall.
- **Reset asserted mid-packet** (DATA state, beat 3 of 8) → next cycle `out_tvalid` = 0 and `err_count` = 0; the next header is processed normally from IDLE.

Source files
------------

// File: rtl/ofs_plat_host_chan_rx_tlp_sequencer_pkg.sv
// ofs_plat_host_chan_rx_tlp_sequencer_pkg: header length decode shared by the host-channel gasket
package ofs_plat_host_chan_rx_tlp_sequencer_pkg;
  typedef enum logic {IDLE, DATA} state_t;
  localparam int BEAT_W = 14;
  localparam int HAS_DATA_BIT = 6;
  function automatic logic [23:0] hdr_bytes(input logic dm, input logic [9:0] len_l,
                                            input logic [1:0] len_m, input logic [11:0] len_h);
    return dm ? {len_h, len_m, len_l} : {11'd0, len_l == 10'd0, len_l, 2'b00};
  endfunction
  function automatic logic [BEAT_W-1:0] exp_beats(input logic [23:0] bytes, input int bpb);
    logic [BEAT_W-1:0] n;
    n = BEAT_W'((25'(bytes) + 25'(bpb) - 25'd1) / 25'(bpb));
    return n == '0 ? BEAT_W'(1) : n;
  endfunction
endpackage

// File: rtl/ofs_plat_host_chan_rx_tlp_seq_skid.sv
// ofs_plat_host_chan_rx_tlp_seq_skid: 2-entry registered skid buffer
module ofs_plat_host_chan_rx_tlp_seq_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_data,
  output logic         deq_valid,
  input  logic         deq_ready,
  output logic [W-1:0] deq_data
);
  logic [W-1:0] mem [2];
  logic wr, rd, push, pop;
  logic [1:0] cnt;
  assign enq_ready = cnt != 2'd2;
  assign deq_valid = cnt != 2'd0;
  assign deq_data = mem[rd];
  assign push = enq_valid & enq_ready;
  assign pop = deq_valid & deq_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
      wr <= 1'b0;
      rd <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) mem[wr] <= enq_data;
      wr <= wr ^ push;
      rd <= rd ^ pop;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/ofs_plat_host_chan_rx_tlp_sequencer.sv
// ofs_plat_host_chan_rx_tlp_sequencer: re-pairs RX headers with their payload and checks payload length
module ofs_plat_host_chan_rx_tlp_sequencer
  import ofs_plat_host_chan_rx_tlp_sequencer_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int HDR_WIDTH = 256,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hdr_tvalid,
  output logic                       hdr_tready,
  input  logic [HDR_WIDTH-1:0]       hdr_tdata,
  input  logic                       hdr_tuser,
  input  logic                       data_tvalid,
  output logic                       data_tready,
  input  logic [TDATA_WIDTH-1:0]     data_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   data_tkeep,
  input  logic                       data_tlast,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [HDR_WIDTH-1:0]       out_hdr,
  output logic                       out_dm_mode,
  output logic [TDATA_WIDTH-1:0]     out_data,
  output logic [TDATA_WIDTH/8-1:0]   out_keep,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic                       out_err_len,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);
  localparam int KW = TDATA_WIDTH / 8;
  localparam int PW = HDR_WIDTH + 1 + TDATA_WIDTH + KW + 3;
  state_t state;
  logic [BEAT_W-1:0] beat_cnt, exp_q, exp_hdr, beat_num, exp_cur;
  logic space, idle, has_data, hdr_pop, data_pop, push, eop, err;
  logic [TDATA_WIDTH-1:0] data;
  logic [KW-1:0] keep;
  logic [PW-1:0] pkt_out;
  assign idle = state == IDLE;
  assign has_data = hdr_tdata[HAS_DATA_BIT];
  assign exp_hdr = exp_beats(hdr_bytes(hdr_tuser, {hdr_tdata[17:16], hdr_tdata[31:24]},
                                       hdr_tdata[19:18], hdr_tdata[43:32]), KW);
  assign hdr_tready = ~reset & space & idle & (~has_data | data_tvalid);
  assign data_tready = ~reset & space & (~idle | (hdr_tvalid & has_data));
  assign hdr_pop = hdr_tvalid & hdr_tready;
  assign data_pop = data_tvalid & data_tready;
  assign push = hdr_pop | data_pop;
  assign eop = data_pop ? data_tlast : 1'b1;
  assign data = data_pop ? data_tdata : '0;
  assign keep = data_pop ? data_tkeep : '0;
  assign beat_num = idle ? BEAT_W'(1) : beat_cnt + BEAT_W'(1);
  assign exp_cur = idle ? exp_hdr : exp_q;
  assign err = data_pop & data_tlast & (beat_num != exp_cur);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat_cnt <= '0;
      exp_q <= '0;
      err_count <= '0;
    end else begin
      if (data_pop) begin
        state <= data_tlast ? IDLE : DATA;
        beat_cnt <= beat_num;
        exp_q <= exp_cur;
      end
      if (err && ~&err_count) err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end
  ofs_plat_host_chan_rx_tlp_seq_skid #(.W(PW)) skid (
    .clk(clk),
    .reset(reset),
    .enq_valid(push),
    .enq_ready(space),
    .enq_data({hdr_tdata, hdr_tuser, data, keep, idle, eop, err}),
    .deq_valid(out_tvalid),
    .deq_ready(out_tready),
    .deq_data(pkt_out)
  );
  assign {out_hdr, out_dm_mode, out_data, out_keep, out_sop, out_eop, out_err_len} = pkt_out;
endmodule

// File: tb/tb_ofs_plat_host_chan_rx_tlp_sequencer.sv
// tb_ofs_plat_host_chan_rx_tlp_sequencer: directed and randomized checks of header/payload re-pairing
module tb_ofs_plat_host_chan_rx_tlp_sequencer;
  localparam int TW = 512, HW = 256, KW = 64, EW = 16;
  typedef struct { logic [HW-1:0] hdr; logic dm; int gap; } hdr_t;
  typedef struct { logic [TW-1:0] data; logic [KW-1:0] keep; logic last; int gap; } dat_t;
  typedef struct { logic [HW-1:0] hdr; logic dm; logic [TW-1:0] data; logic [KW-1:0] keep; logic sop, eop, err; } beat_t;
  logic clk = 0, reset = 1;
  logic hdr_tvalid, hdr_tready, hdr_tuser, data_tvalid, data_tready, data_tlast;
  logic out_tvalid, out_tready, out_dm_mode, out_sop, out_eop, out_err_len;
  logic [HW-1:0] hdr_tdata, out_hdr;
  logic [TW-1:0] data_tdata, out_data;
  logic [KW-1:0] data_tkeep, out_keep;
  logic [EW-1:0] err_count;
  hdr_t hq[$];
  dat_t dq[$];
  beat_t eq[$];
  int fires[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, rdy_pct = 100, h_acc = 0, n_err = 0, pid = 0, d_cyc = 0;
  logic h_busy = 0, d_busy = 0, rnd = 0;
  logic [KW-1:0] kfix = '1;

  ofs_plat_host_chan_rx_tlp_sequencer dut (
    .clk(clk), .reset(reset),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready), .hdr_tdata(hdr_tdata), .hdr_tuser(hdr_tuser),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_hdr(out_hdr), .out_dm_mode(out_dm_mode),
    .out_data(out_data), .out_keep(out_keep), .out_sop(out_sop), .out_eop(out_eop),
    .out_err_len(out_err_len), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [7:0] ft, input logic [23:0] len, input logic dm, input int id);
    logic [HW-1:0] h;
    h = '0;
    h[95:64] = id;
    h[255:224] = 32'hC0DE_0000 ^ id;
    h[7:0] = ft;
    h[31:24] = len[7:0];
    h[17:16] = len[9:8];
    h[19:18] = dm ? len[11:10] : 2'b10;
    h[43:32] = dm ? len[23:12] : 12'hABC;
    return h;
  endfunction

  function automatic int want_beats(input logic [23:0] len, input logic dm);
    int bytes, b;
    bytes = dm ? int'(len) : (len[9:0] == 10'd0 ? 4096 : 4 * int'(len[9:0]));
    b = (bytes + 63) / 64;
    return b == 0 ? 1 : b;
  endfunction

  task automatic add_pkt(input logic [7:0] ft, input logic [23:0] len, input logic dm, input int nb,
                         input int hgap, input int dgap, input logic done = 1'b1);
    hdr_t h;
    dat_t d;
    beat_t e;
    int w;
    h.hdr = mk_hdr(ft, len, dm, pid);
    pid++;
    h.dm = dm;
    h.gap = hgap;
    hq.push_back(h);
    w = want_beats(len, dm);
    e.hdr = h.hdr;
    e.dm = dm;
    if (!ft[6]) begin
      e.data = '0; e.keep = '0; e.sop = 1; e.eop = 1; e.err = 0;
      eq.push_back(e);
    end else begin
      for (int i = 0; i < nb; i++) begin
        d.data = {16{$urandom}};
        d.keep = rnd ? {$urandom, $urandom} : kfix;
        d.last = done && i == nb - 1;
        d.gap = i == 0 ? dgap : (rnd ? int'($urandom_range(1)) : 0);
        dq.push_back(d);
        e.data = d.data; e.keep = d.keep; e.sop = i == 0; e.eop = d.last;
        e.err = d.last && nb != w;
        if (e.err) n_err++;
        eq.push_back(e);
      end
    end
  endtask

  task automatic drain(input int lim);
    int i;
    i = 0;
    while ((eq.size() != 0 || hq.size() != 0 || dq.size() != 0 || h_busy || d_busy) && i < lim) begin
      @(posedge clk);
      i++;
    end
    check("drain", 600'({32'(eq.size()), 32'(hq.size()), 32'(dq.size()), h_busy, d_busy}), 600'(0));
  endtask

  initial begin
    hdr_t h;
    hdr_tvalid = 0; hdr_tdata = '0; hdr_tuser = 0;
    @(posedge clk); #1;
    forever begin
      if (hq.size() == 0) begin
        hdr_tvalid = 0;
        @(posedge clk); #1;
      end else begin
        h = hq.pop_front();
        h_busy = 1;
        hdr_tvalid = 0;
        repeat (h.gap) begin @(posedge clk); #1; end
        hdr_tvalid = 1; hdr_tdata = h.hdr; hdr_tuser = h.dm;
        @(negedge clk);
        while (!hdr_tready) @(negedge clk);
        h_acc++;
        @(posedge clk); #1;
        h_busy = 0;
      end
    end
  end

  initial begin
    dat_t d;
    data_tvalid = 0; data_tdata = '0; data_tkeep = '0; data_tlast = 0;
    @(posedge clk); #1;
    forever begin
      if (dq.size() == 0) begin
        data_tvalid = 0;
        @(posedge clk); #1;
      end else begin
        d = dq.pop_front();
        d_busy = 1;
        data_tvalid = 0;
        repeat (d.gap) begin @(posedge clk); #1; end
        data_tvalid = 1; data_tdata = d.data; data_tkeep = d.keep; data_tlast = d.last;
        @(negedge clk);
        while (!data_tready) @(negedge clk);
        d_cyc = cyc;
        @(posedge clk); #1;
        d_busy = 0;
      end
    end
  end

  initial begin
    out_tready = 1;
    forever begin
      @(posedge clk); #1;
      out_tready = int'($urandom_range(99)) < rdy_pct;
    end
  end

  initial begin
    beat_t e;
    logic [599:0] prev_c, prev_d;
    logic held;
    held = 0;
    forever begin
      @(negedge clk);
      if (reset) held = 0;
      else begin
        if (held && out_tvalid) begin
          check("stable_ctl", 600'({out_hdr, out_dm_mode, out_sop, out_eop, out_err_len, out_keep}), prev_c);
          check("stable_data", 600'(out_data), prev_d);
        end
        if (out_tvalid && out_tready) begin
          fires.push_back(cyc);
          if (eq.size() == 0) check("extra_beat", 600'(1), 600'(0));
          else begin
            e = eq.pop_front();
            check("beat_ctl", 600'({out_sop, out_eop, out_err_len, out_keep}), 600'({e.sop, e.eop, e.err, e.keep}));
            check("beat_data", 600'(out_data), 600'(e.data));
            if (e.sop) check("beat_hdr", 600'({out_dm_mode, out_hdr}), 600'({e.dm, e.hdr}));
          end
        end
        held = out_tvalid && !out_tready;
        prev_c = 600'({out_hdr, out_dm_mode, out_sop, out_eop, out_err_len, out_keep});
        prev_d = 600'(out_data);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dat_t d;
    int h0, t, w, nb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 600'(out_tvalid), 600'(0));
    check("rst_readies", 600'({hdr_tready, data_tready}), 600'(0));
    check("rst_errcnt", 600'(err_count), 600'(0));
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk);

    add_pkt(8'h60, 24'd32, 0, 2, 0, 0);
    drain(200);
    check("pu_wr_errcnt", 600'(err_count), 600'(0));

    fires.delete();
    kfix = 64'hFFFF;
    add_pkt(8'h20, 24'd16, 0, 0, 0, 0);
    add_pkt(8'h4A, 24'd4, 0, 1, 0, 0);
    drain(200);
    kfix = '1;
    check("hdronly_cpl_beats", 600'(fires.size()), 600'(2));
    if (fires.size() == 2) check("hdronly_cpl_gap", 600'(fires[1] - fires[0]), 600'(1));

    fires.delete();
    add_pkt(8'h60, 24'd16, 0, 1, 0, 5);
    repeat (3) begin
      @(negedge clk);
      check("early_hdr_held", 600'({hdr_tvalid, hdr_tready, out_tvalid}), 600'(3'b100));
    end
    drain(200);
    check("early_hdr_beats", 600'(fires.size()), 600'(1));
    if (fires.size() == 1) check("early_hdr_latency", 600'(fires[0] - d_cyc), 600'(1));

    add_pkt(8'h60, 24'd16, 0, 2, 0, 0);
    drain(200);
    check("len_mismatch_errcnt", 600'(err_count), 600'(1));
    add_pkt(8'h60, 24'd0, 0, 64, 0, 0);
    drain(400);
    check("len_1024dw_errcnt", 600'(err_count), 600'(1));

    rdy_pct = 0;
    repeat (2) @(posedge clk);
    h0 = h_acc;
    repeat (3) add_pkt(8'h20, 24'd1, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("stall_accepted", 600'(h_acc - h0), 600'(2));
    check("stall_readies", 600'({out_tvalid, hdr_tready}), 600'(2'b10));
    rdy_pct = 100;
    drain(200);

    fires.delete();
    add_pkt(8'h60, 24'd32, 0, 2, 0, 0);
    add_pkt(8'h20, 24'd1, 0, 0, 0, 0);
    add_pkt(8'h60, 24'd16, 0, 1, 0, 0);
    drain(200);
    check("b2b_beats", 600'(fires.size()), 600'(4));
    if (fires.size() == 4) check("b2b_span", 600'(fires[3] - fires[0]), 600'(3));

    rnd = 1;
    rdy_pct = 50;
    for (int i = 0; i < 100; i++) begin
      t = int'($urandom_range(2));
      if (t == 0) add_pkt(8'h20, 24'($urandom_range(255)), 0, 0, int'($urandom_range(2)), 0);
      else begin
        logic [23:0] len;
        len = t == 1 ? 24'($urandom_range(256, 1)) : 24'($urandom_range(2000));
        w = want_beats(len, t == 2);
        case ($urandom_range(4))
          0: nb = w - 1;
          1: nb = w + 1;
          default: nb = w;
        endcase
        if (nb < 1) nb = 1;
        add_pkt(8'h60, len, t == 2, nb, int'($urandom_range(2)), int'($urandom_range(2)));
      end
    end
    drain(30000);
    check("random_errcnt", 600'(err_count), 600'(n_err));
    rnd = 0;
    rdy_pct = 100;

    add_pkt(8'h60, 24'd128, 0, 2, 0, 0, 1'b0);
    drain(200);
    rdy_pct = 0;
    repeat (2) @(posedge clk);
    d.data = {16{32'h5A5A_0003}}; d.keep = '1; d.last = 0; d.gap = 0;
    dq.push_back(d);
    drain(50);
    @(negedge clk);
    check("midpkt_pending", 600'({out_tvalid, out_sop, data_tready}), 600'(3'b101));
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    check("midpkt_rst_readies", 600'({hdr_tready, data_tready}), 600'(0));
    @(posedge clk); #1;
    reset = 0;
    eq.delete();
    rdy_pct = 100;
    @(negedge clk);
    check("midpkt_post_rst", 600'({out_tvalid, err_count}), 600'(0));
    fires.delete();
    add_pkt(8'h60, 24'd32, 0, 2, 0, 0);
    drain(200);
    check("post_rst_beats", 600'(fires.size()), 600'(2));
    check("post_rst_errcnt", 600'(err_count), 600'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
